// File: rtl/lcd_text_formatter.sv
// Character-LCD text feeder: snapshots value/switches, runs a serial double-dabble conversion,
// then publishes two 16-char ASCII lines. Optional macro LCD_FMT_LZB_EN enables leading-zero blanking.
module lcd_text_formatter #(
  parameter int unsigned VALUE_W        = 16,
  parameter int unsigned DIGITS         = 5,
  parameter int unsigned REFRESH_CYCLES = 12500000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [VALUE_W-1:0] value_i,
  input  logic [3:0]         sw_p_i,
  input  logic               force_i,
  output logic [127:0]       line1_o,
  output logic [127:0]       line2_o,
  output logic               update_o,
  output logic               busy_o
);

  localparam int unsigned BCD_W  = 4 * DIGITS;
  localparam int unsigned ITER_W = $clog2(VALUE_W + 1);
  localparam int unsigned HOLD_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES + 1) : 1;
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(VALUE_W - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((REFRESH_CYCLES == 0) ? 0 : REFRESH_CYCLES - 1);
  localparam logic [55:0]  PFX1  = "COUNT: ";
  localparam logic [23:0]  PFX2  = "SW:";
  localparam logic [127:0] BLANK = {16{8'h20}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONVERT,
    S_FORMAT,
    S_PUBLISH,
    S_HOLDOFF
  } state_t;

  state_t             state_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [VALUE_W-1:0] shift_q;
  logic [ITER_W-1:0]  iter_q;
  logic [HOLD_W-1:0]  hold_q;
  logic [VALUE_W-1:0] snap_value_q;
  logic [3:0]         snap_sw_q;
  logic [VALUE_W-1:0] pub_value_q;
  logic [3:0]         pub_sw_q;
  logic               snap_valid_q;
  logic               force_pend_q;
  logic [127:0]       line1_q;
  logic [127:0]       line2_q;
  logic               update_q;
  logic               busy_q;

  logic [BCD_W-1:0]   bcd_adj;
  logic [127:0]       line1_d;
  logic [127:0]       line2_d;
  logic [3:0]         nib;
  logic [7:0]         ch;
  logic               capture;
`ifdef LCD_FMT_LZB_EN
  logic               lead;
`endif

  assign line1_o  = line1_q;
  assign line2_o  = line2_q;
  assign update_o = update_q;
  assign busy_o   = busy_q;

  // Republish on first run, any input difference from what is on screen, or a pending force.
  assign capture = (state_q == S_IDLE) &&
                   (!snap_valid_q || (value_i != pub_value_q) ||
                    (sw_p_i != pub_sw_q) || force_pend_q);

  // Double-dabble correction: bump every nibble >= 5 before the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    line1_d = BLANK;
    line2_d = BLANK;
    nib     = 4'd0;
    ch      = 8'h20;
`ifdef LCD_FMT_LZB_EN
    lead    = 1'b1;
`endif
    line1_d[127 -: 56] = PFX1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      nib = bcd_q[4*(int'(DIGITS)-1-i) +: 4];
      ch  = {4'h3, nib};
`ifdef LCD_FMT_LZB_EN
      // Least significant digit is always shown so zero renders as "0".
      if ((nib != 4'd0) || (i == int'(DIGITS) - 1)) lead = 1'b0;
      if (lead) ch = 8'h20;
`endif
      if (7 + i < 16) line1_d[127-8*(7+i) -: 8] = ch;
    end
    line2_d[127 -: 24] = PFX2;
    for (int j = 0; j < 4; j++) begin
      line2_d[127-8*(3+j) -: 8] = snap_sw_q[3-j] ? 8'h31 : 8'h30;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      bcd_q        <= '0;
      shift_q      <= '0;
      iter_q       <= '0;
      hold_q       <= '0;
      snap_value_q <= '0;
      snap_sw_q    <= '0;
      pub_value_q  <= '0;
      pub_sw_q     <= '0;
      snap_valid_q <= 1'b0;
      force_pend_q <= 1'b0;
      line1_q      <= BLANK;
      line2_q      <= BLANK;
      update_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      update_q     <= 1'b0;
      force_pend_q <= capture ? 1'b0 : (force_pend_q | force_i);
      case (state_q)
        S_IDLE: begin
          if (capture) begin
            snap_value_q <= value_i;
            snap_sw_q    <= sw_p_i;
            shift_q      <= value_i;
            bcd_q        <= '0;
            iter_q       <= '0;
            busy_q       <= 1'b1;
            state_q      <= S_CONVERT;
          end
        end
        S_CONVERT: begin
          bcd_q   <= {bcd_adj[BCD_W-2:0], shift_q[VALUE_W-1]};
          shift_q <= {shift_q[VALUE_W-2:0], 1'b0};
          iter_q  <= iter_q + ITER_W'(1);
          if (iter_q == ITER_LAST) state_q <= S_FORMAT;
        end
        S_FORMAT: begin
          line1_q      <= line1_d;
          line2_q      <= line2_d;
          snap_valid_q <= 1'b1;
          pub_value_q  <= snap_value_q;
          pub_sw_q     <= snap_sw_q;
          state_q      <= S_PUBLISH;
        end
        S_PUBLISH: begin
          update_q <= 1'b1;
          hold_q   <= '0;
          if (REFRESH_CYCLES == 0) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            state_q <= S_HOLDOFF;
          end
        end
        S_HOLDOFF: begin
          if (hold_q == HOLD_LAST) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            hold_q <= hold_q + HOLD_W'(1);
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/lcd_text_formatter.md
Name: lcd_text_formatter

Overview:
- Upstream feeder for the character-LCD driver.
- Snapshots a binary counter value and the 4 board switches, then converts the value to decimal with a sequential double-dabble engine.
- Assembles two 16-character ASCII lines and pulses update to the LCD driver.
- Rate-limits republishing so the LCD driver is not retriggered faster than it can redraw.

Parameters:
VALUE_W, 16, width of binary input value
DIGITS, 5, decimal digits produced; must satisfy 10^DIGITS > 2^VALUE_W-1
REFRESH_CYCLES, 12500000, minimum clocks between successive update pulses; 0 = no holdoff

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
value  input  VALUE_W  binary count to display
sw_p  input  4  switch states to display
force  input  1  one-cycle request to republish even if inputs are unchanged
line1  output  128  ASCII line 1; char 0 in [127:120], char 15 in [7:0]
line2  output  128  ASCII line 2, same packing
update  output  1  one-cycle pulse: new text is present on line1/line2
busy  output  1  high in every state except IDLE

Behaviour:
Reset:
- Applies immediately on rst (asynchronous, active-high).
- line1 and line2 = all 0x20 (spaces); update=0; busy=0; state=IDLE.
- snapshot-valid flag cleared; force-pending flag cleared.

Force handling:
- force is latched into the force-pending flag in any state.
- The flag clears when IDLE captures.

State machine (IDLE, CONVERT, FORMAT, PUBLISH, HOLDOFF):
- IDLE: capture when any of the following holds: snapshot-valid=0; value != last published value; sw_p != last published sw_p; force-pending=1. On capture: latch value/sw_p into the snapshot, clear BCD register (4*DIGITS bits), clear force-pending, go to CONVERT.
- CONVERT: exactly VALUE_W cycles. Each cycle, add 3 to every BCD nibble >= 5, then shift {bcd, shift_reg} left by 1 (value MSB first). An iteration counter of width clog2(VALUE_W+1) ends the state.
- FORMAT: 1 cycle. Write line1 and line2 per the layouts below. Set snapshot-valid=1 and record the published value/sw_p.
- PUBLISH: 1 cycle with update=1. Next state is HOLDOFF, or IDLE if REFRESH_CYCLES=0.
- HOLDOFF: count to REFRESH_CYCLES-1, then go to IDLE. The counter is wide enough for REFRESH_CYCLES.

Timing:
- For a capture at edge k, line1/line2 change at edge k+VALUE_W+1 and update is high for the cycle after edge k+VALUE_W+2.
- Lines are stable from that point until the next FORMAT.
- update is never high for two consecutive cycles.

Input changes while busy:
- value/sw_p changes during CONVERT/FORMAT/PUBLISH/HOLDOFF do not affect the conversion in flight.
- They are not lost: IDLE compares against the last published snapshot.
- Intermediate values may be skipped; the final value is always displayed.
- If a change and force occur together, only one capture results.

Line layouts:
- line1: chars 0-6 = "COUNT: ", chars 7..7+DIGITS-1 = decimal digits, most significant first, each nibble+0x30; remaining chars = spaces.
- line2: chars 0-2 = "SW:", chars 3-6 = '1'/'0' for sw_p[3], sw_p[2], sw_p[1], sw_p[0]; remaining chars = spaces.

Reset mid-operation:
- Abandons any conversion and restores the reset values.
- snapshot-valid=0, so the first IDLE cycle after reset release captures and republishes.

Optional Feature:
Macro: LCD_FMT_LZB_EN (leading-zero blanking).
- Defined: in FORMAT, leading zero digits are replaced by 0x20; the least significant digit is always shown. Value 0 gives "COUNT:     0". Digit positions are unchanged (right-aligned).
- Not defined: all DIGITS digits are shown, including leading zeros.
- Latency is identical in both builds.

Test Plan:
- REFRESH_CYCLES=100, release reset with value=0, sw_p=0 -> single update pulse 18 cycles after release; line1="COUNT: 00000    " ("COUNT:     0    " with LCD_FMT_LZB_EN); line2="SW:0000         ".
- value=12345, sw_p=4'b1010 -> line1="COUNT: 12345    ", line2="SW:1010         ", update high exactly one cycle, busy high from capture through HOLDOFF.
- value=65535 (max) -> "COUNT: 65535    ". Then value=7 -> "COUNT: 00007    " (LZB build: "COUNT:     7    ").
- Change value 3 times during HOLDOFF (1,2,3), final value 3 -> exactly one further update after holdoff expires, showing 3. Interval between update pulses >= 100 cycles.
- Hold inputs constant and pulse force once during CONVERT -> current publish completes; a second update with identical text follows after holdoff; no third update.
- Assert rst during CONVERT -> lines return to spaces immediately, update=0. After release, republish with current inputs at 18 cycles.
